// File: rtl/pattern_playback_pkg.sv
// rtl/pattern_playback_pkg.sv - shared states, defaults and address helper for the pattern path
package pattern_playback_pkg;

  localparam int DEFAULT_SAMPLES = 128;
  localparam int DEFAULT_OSF     = 8;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_PRIME = 2'd1,
    ST_RUN   = 2'd2,
    ST_DONE  = 2'd3
  } state_e;

  function automatic int addr_w(input int samples);
    return (samples > 1) ? $clog2(samples) : 1;
  endfunction

endpackage

// File: rtl/pattern_playback_ram.sv
// rtl/pattern_playback_ram.sv - SAMPLES x DW simple dual-port RAM, sync write, 1-clock sync read
// Read-during-write to the same address returns the new data, so a write issued with Start is seen by the first fetch.
module pattern_ram
  import pattern_playback_pkg::*;
#(
  parameter  int SAMPLES = DEFAULT_SAMPLES,
  parameter  int DW      = 12,
  localparam int AW      = addr_w(SAMPLES)
) (
  input  logic          Clk,
  input  logic          wr_en_i,
  input  logic [AW-1:0] wr_addr_i,
  input  logic [DW-1:0] wr_data_i,
  input  logic [AW-1:0] rd_addr_i,
  output logic [DW-1:0] rd_data_o
);

  logic [DW-1:0] mem_q [SAMPLES];
  logic [DW-1:0] rd_q;

  always_ff @(posedge Clk) begin
    if (wr_en_i) mem_q[wr_addr_i] <= wr_data_i;
    if (wr_en_i && (wr_addr_i == rd_addr_i)) rd_q <= wr_data_i;
    else                                     rd_q <= mem_q[rd_addr_i];
  end

  assign rd_data_o = rd_q;

endmodule

// File: rtl/pattern_playback.sv
// rtl/pattern_playback.sv - oversampled pattern playback feeding the pattern counter
// PATTERN_LOOP_EN: DONE re-enters RUN at sample 0 instead of returning to IDLE.
module pattern_playback
  import pattern_playback_pkg::*;
#(
  parameter  int SAMPLES = DEFAULT_SAMPLES,
  parameter  int OSF     = DEFAULT_OSF,
  parameter  int DW      = 12,
  parameter  int DIV     = 1,
  localparam int AW      = addr_w(SAMPLES)
) (
  input  logic          Clk,
  input  logic          Reset,
  input  logic          Start,
  input  logic          Abort,
  input  logic          Wr_En,
  input  logic [AW-1:0] Wr_Addr,
  input  logic [DW-1:0] Wr_Data,
  input  logic          Frame_Done,
  output logic          Tick,
  output logic          Cnt_Clr,
  output logic [DW-1:0] Sample_Out,
  output logic          Sample_Valid,
  output logic          Busy,
  output logic          Done,
  output logic          Sync_Err
);

  localparam int OW  = (OSF > 1) ? $clog2(OSF) : 1;
  localparam int DVW = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [AW-1:0]  IDX_LAST = AW'(SAMPLES - 1);
  localparam logic [OW-1:0]  OS_LAST  = OW'(OSF - 1);
  localparam logic [DVW-1:0] DIV_LAST = DVW'(DIV - 1);

  state_e         state_q;
  logic [AW-1:0]  idx_q;
  logic [OW-1:0]  os_q;
  logic [DVW-1:0] div_q;
  logic [DW-1:0]  sample_q;
  logic           valid_q, done_q, clr_q, err_q;

  logic           tick;
  logic           ram_we;
  logic [AW-1:0]  rd_addr;
  logic [DW-1:0]  rd_data;

  assign tick    = (state_q == ST_RUN) && (div_q == DIV_LAST);
  assign ram_we  = Wr_En && (state_q == ST_IDLE);
  // Outside RUN the read port sits on sample 0 so the first fetch is ready when PRIME ends.
  assign rd_addr = (state_q == ST_RUN) ? idx_q + AW'(1) : '0;

  pattern_ram #(.SAMPLES(SAMPLES), .DW(DW)) u_ram (
    .Clk       (Clk),
    .wr_en_i   (ram_we),
    .wr_addr_i (Wr_Addr),
    .wr_data_i (Wr_Data),
    .rd_addr_i (rd_addr),
    .rd_data_o (rd_data)
  );

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_q  <= ST_IDLE;
      idx_q    <= '0;
      os_q     <= '0;
      div_q    <= '0;
      sample_q <= '0;
      valid_q  <= 1'b0;
      done_q   <= 1'b0;
      clr_q    <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      done_q <= 1'b0;
      clr_q  <= 1'b0;
      // The counter's flag must rise exactly on the DONE clock, never earlier.
      if ((state_q == ST_RUN) && Frame_Done)   err_q <= 1'b1;
      if ((state_q == ST_DONE) && !Frame_Done) err_q <= 1'b1;

      if (Abort) begin
        state_q <= ST_IDLE;
        valid_q <= 1'b0;
        clr_q   <= 1'b1;
      end else begin
        unique case (state_q)
          ST_IDLE: begin
            if (Start) begin
              state_q <= ST_PRIME;
              idx_q   <= '0;
              os_q    <= '0;
              div_q   <= '0;
              clr_q   <= 1'b1;
              err_q   <= 1'b0;
            end
          end
          ST_PRIME: begin
            state_q  <= ST_RUN;
            sample_q <= rd_data;
            valid_q  <= 1'b1;
          end
          ST_RUN: begin
            if (tick) begin
              div_q <= '0;
              if (os_q == OS_LAST) begin
                os_q     <= '0;
                idx_q    <= idx_q + AW'(1);
                sample_q <= rd_data;
                if (idx_q == IDX_LAST) begin
                  state_q <= ST_DONE;
                  done_q  <= 1'b1;
                  clr_q   <= 1'b1;
                  valid_q <= 1'b0;
                end
              end else begin
                os_q <= os_q + OW'(1);
              end
            end else begin
              div_q <= div_q + DVW'(1);
            end
          end
          ST_DONE: begin
`ifdef PATTERN_LOOP_EN
            state_q  <= ST_RUN;
            idx_q    <= '0;
            os_q     <= '0;
            div_q    <= '0;
            sample_q <= rd_data;
            valid_q  <= 1'b1;
`else
            state_q  <= ST_IDLE;
`endif
          end
        endcase
      end
    end
  end

  assign Tick         = tick;
  assign Cnt_Clr      = clr_q;
  assign Sample_Out   = sample_q;
  assign Sample_Valid = valid_q;
  assign Busy         = (state_q != ST_IDLE);
  assign Done         = done_q;
  assign Sync_Err     = err_q;

endmodule

// File: tb/tb_pattern_playback.sv
// tb/tb_pattern_playback.sv - scoreboard bench for pattern_playback with modelled pattern counters
`timescale 1ns/1ps
module tb_pattern_playback;

  localparam int S  = 128, O  = 8, D  = 1, W = 12;
  localparam int SB = 4,   OB = 2, DB = 3;

  logic Clk = 1'b0;
  always #5 Clk = ~Clk;

  logic         Reset, Start, Abort, Wr_En, force_fd;
  logic [6:0]   Wr_Addr;
  logic [W-1:0] Wr_Data, Sample_Out;
  logic         Frame_Done, Tick, Cnt_Clr, Sample_Valid, Busy, Done, Sync_Err;
  logic [10:0]  cnt_q;

  logic         b_Start, b_Abort, b_Wr_En;
  logic [1:0]   b_Wr_Addr;
  logic [W-1:0] b_Wr_Data, b_Sample_Out;
  logic         b_Frame_Done, b_Tick, b_Cnt_Clr, b_Sample_Valid, b_Busy, b_Done, b_Sync_Err;
  logic [3:0]   b_cnt_q;

  int checks = 0;
  int errors = 0;
  int sb[$];
  logic [W-1:0] mem_a [S];
  logic [W-1:0] mem_b [SB];

  pattern_playback #(.SAMPLES(S), .OSF(O), .DW(W), .DIV(D)) dut (
    .Clk(Clk), .Reset(Reset), .Start(Start), .Abort(Abort), .Wr_En(Wr_En),
    .Wr_Addr(Wr_Addr), .Wr_Data(Wr_Data), .Frame_Done(Frame_Done), .Tick(Tick),
    .Cnt_Clr(Cnt_Clr), .Sample_Out(Sample_Out), .Sample_Valid(Sample_Valid),
    .Busy(Busy), .Done(Done), .Sync_Err(Sync_Err)
  );

  pattern_playback #(.SAMPLES(SB), .OSF(OB), .DW(W), .DIV(DB)) dut_b (
    .Clk(Clk), .Reset(Reset), .Start(b_Start), .Abort(b_Abort), .Wr_En(b_Wr_En),
    .Wr_Addr(b_Wr_Addr), .Wr_Data(b_Wr_Data), .Frame_Done(b_Frame_Done), .Tick(b_Tick),
    .Cnt_Clr(b_Cnt_Clr), .Sample_Out(b_Sample_Out), .Sample_Valid(b_Sample_Valid),
    .Busy(b_Busy), .Done(b_Done), .Sync_Err(b_Sync_Err)
  );

  // Pattern counters: cleared by Cnt_Clr, count on Tick, terminal at SAMPLES*OSF.
  always_ff @(posedge Clk) begin
    if (Reset || Cnt_Clr) cnt_q <= '0;
    else if (Tick)        cnt_q <= cnt_q + 11'd1;
    if (Reset || b_Cnt_Clr) b_cnt_q <= '0;
    else if (b_Tick)        b_cnt_q <= b_cnt_q + 4'd1;
  end
  assign Frame_Done   = force_fd || (cnt_q == 11'(S * O));
  assign b_Frame_Done = (b_cnt_q == 4'(SB * OB));

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic push_main();
    for (int s = 0; s < S; s++)
      for (int o = 0; o < O; o++)
        sb.push_back(int'(mem_a[s]));
  endtask

  task automatic start_main();
    @(negedge Clk);
    Start = 1'b1;
    push_main();
    @(negedge Clk);
    Start = 1'b0;
    Wr_En = 1'b0;
    check("prime_busy", 32'(Busy), 32'd1);
    check("prime_clr", 32'(Cnt_Clr), 32'd1);
    check("prime_tick", 32'(Tick), 32'd0);
    check("prime_syncerr", 32'(Sync_Err), 32'd0);
  endtask

  // Runs from the first RUN clock; returns at the DONE clock, after an abort, or at the bound.
  task automatic play_main(input int abort_tick, input int force_tick, input int wr_tick,
                           output int ticks, output int done_cyc);
    int exp;
    ticks = 0;
    done_cyc = -1;
    for (int cyc = 1; cyc < 3000; cyc++) begin
      @(negedge Clk);
      force_fd = 1'b0;
      Wr_En    = 1'b0;
      if (Done) begin
        done_cyc = cyc;
        return;
      end
      if (Tick) begin
        ticks++;
        exp = (sb.size() > 0) ? sb.pop_front() : 32'hDEAD;
        check("sample", 32'(Sample_Out), 32'(exp));
        check("valid", 32'(Sample_Valid), 32'd1);
        if (ticks == force_tick) force_fd = 1'b1;
        if (ticks == wr_tick) begin
          Wr_En = 1'b1; Wr_Addr = 7'd5; Wr_Data = 12'hABC;
        end
        if (ticks == abort_tick) begin
          Abort = 1'b1;
          @(negedge Clk);
          Abort = 1'b0;
          check("abort_tick", 32'(Tick), 32'd0);
          check("abort_busy", 32'(Busy), 32'd0);
          check("abort_valid", 32'(Sample_Valid), 32'd0);
          check("abort_clr", 32'(Cnt_Clr), 32'd1);
          check("abort_done", 32'(Done), 32'd0);
          sb.delete();
          return;
        end
      end
    end
  endtask

  task automatic check_done_clock(input logic exp_err);
    check("done_pulse", 32'(Done), 32'd1);
    check("done_clr", 32'(Cnt_Clr), 32'd1);
    check("done_tick", 32'(Tick), 32'd0);
    check("done_valid", 32'(Sample_Valid), 32'd0);
    check("done_framedone", 32'(Frame_Done), 32'd1);
    check("done_syncerr", 32'(Sync_Err), 32'(exp_err));
    @(negedge Clk);
    check("post_busy", 32'(Busy), 32'd0);
    check("post_done", 32'(Done), 32'd0);
    check("post_syncerr", 32'(Sync_Err), 32'(exp_err));
    check("sb_empty", 32'(sb.size()), 32'd0);
  endtask

  initial begin
    int ticks, done_cyc, exp, p, b_ticks, frames;
    Reset = 1'b1; Start = 1'b0; Abort = 1'b0; Wr_En = 1'b0; Wr_Addr = '0; Wr_Data = '0;
    force_fd = 1'b0;
    b_Start = 1'b0; b_Abort = 1'b0; b_Wr_En = 1'b0; b_Wr_Addr = '0; b_Wr_Data = '0;
    repeat (3) @(negedge Clk);
    Reset = 1'b0;

    check("rst_tick", 32'(Tick), 32'd0);
    check("rst_clr", 32'(Cnt_Clr), 32'd0);
    check("rst_valid", 32'(Sample_Valid), 32'd0);
    check("rst_busy", 32'(Busy), 32'd0);
    check("rst_done", 32'(Done), 32'd0);
    check("rst_syncerr", 32'(Sync_Err), 32'd0);
    check("rst_sample", 32'(Sample_Out), 32'd0);
    check("rst_b_busy", 32'(b_Busy), 32'd0);

`ifndef PATTERN_LOOP_EN
    // Fill data=addr, with addr 0 first holding a decoy rewritten in the Start clock.
    for (int a = 0; a < S; a++) begin
      @(negedge Clk);
      Wr_En = 1'b1; Wr_Addr = 7'(a); Wr_Data = (a == 0) ? 12'hFFF : 12'(a);
      mem_a[a] = Wr_Data;
    end
    @(negedge Clk);
    Wr_En = 1'b1; Wr_Addr = 7'd0; Wr_Data = 12'd0; mem_a[0] = 12'd0;
    Start = 1'b1;
    push_main();
    @(negedge Clk);
    Start = 1'b0; Wr_En = 1'b0;
    check("f1_prime_busy", 32'(Busy), 32'd1);
    check("f1_prime_clr", 32'(Cnt_Clr), 32'd1);
    play_main(0, 0, 0, ticks, done_cyc);
    check("f1_ticks", 32'(ticks), 32'(S * O));
    check("f1_done_cycle", 32'(done_cyc), 32'(S * O + 1));
    check_done_clock(1'b0);

    // Write during RUN is dropped; an early Frame_Done raises Sync_Err.
    start_main();
    play_main(0, 100, 10, ticks, done_cyc);
    check("f2_ticks", 32'(ticks), 32'(S * O));
    check("f2_done_cycle", 32'(done_cyc), 32'(S * O + 1));
    check_done_clock(1'b1);

    start_main();
    play_main(500, 0, 0, ticks, done_cyc);
    check("f3_ticks_at_abort", 32'(ticks), 32'd500);
    @(negedge Clk);
    check("f3_no_done", 32'(Done), 32'd0);
    check("f3_clr_one_clock", 32'(Cnt_Clr), 32'd0);

    start_main();
    play_main(0, 0, 0, ticks, done_cyc);
    check("f4_ticks", 32'(ticks), 32'(S * O));
    check("f4_done_cycle", 32'(done_cyc), 32'(S * O + 1));
    check_done_clock(1'b0);
`endif

    for (int a = 0; a < SB; a++) begin
      @(negedge Clk);
      b_Wr_En = 1'b1; b_Wr_Addr = 2'(a); b_Wr_Data = 12'(12'h300 + a * 17);
      mem_b[a] = b_Wr_Data;
    end
`ifdef PATTERN_LOOP_EN
    frames = 2;
`else
    frames = 1;
`endif
    @(negedge Clk);
    b_Wr_En = 1'b0;
    b_Start = 1'b1;
    // One entry per RUN/DONE clock: sample value, or -1 for the DONE gap.
    for (int f = 0; f < frames; f++)
      for (int q = 0; q < 25; q++)
        sb.push_back((q == 24) ? -1 : int'(mem_b[q / 6]));
    @(negedge Clk);
    b_Start = 1'b0;
    check("b_prime_clr", 32'(b_Cnt_Clr), 32'd1);
    b_ticks = 0;
    for (int cyc = 1; cyc <= frames * 25; cyc++) begin
      @(negedge Clk);
      p = (cyc - 1) % 25;
      exp = (sb.size() > 0) ? sb.pop_front() : -2;
      if (b_Tick) b_ticks++;
      if (exp == -1) begin
        check("b_done", 32'(b_Done), 32'd1);
        check("b_done_valid", 32'(b_Sample_Valid), 32'd0);
        check("b_done_framedone", 32'(b_Frame_Done), 32'd1);
        check("b_done_clr", 32'(b_Cnt_Clr), 32'd1);
      end else begin
        check("b_sample", 32'(b_Sample_Out), 32'(exp));
        check("b_valid", 32'(b_Sample_Valid), 32'd1);
        check("b_tick", 32'(b_Tick), 32'((p % 3) == 2));
        check("b_no_done", 32'(b_Done), 32'd0);
      end
    end
    check("b_ticks", 32'(b_ticks), 32'(frames * SB * OB));
    check("b_syncerr", 32'(b_Sync_Err), 32'd0);
`ifdef PATTERN_LOOP_EN
    @(negedge Clk);
    check("b_loop_running", 32'(b_Busy), 32'd1);
    b_Abort = 1'b1;
    @(negedge Clk);
    b_Abort = 1'b0;
    check("b_abort_busy", 32'(b_Busy), 32'd0);
    check("b_abort_tick", 32'(b_Tick), 32'd0);
    check("b_abort_done", 32'(b_Done), 32'd0);
`else
    @(negedge Clk);
    check("b_idle_busy", 32'(b_Busy), 32'd0);
    check("b_idle_valid", 32'(b_Sample_Valid), 32'd0);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
